// File: rtl/mmio_io_responder_if.sv
// CPU data-memory bus, instruction-retire strobe and UART byte handshakes for mmio_io_responder.
interface mmio_io_responder_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic        instr_retired;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport slave (
        input  addr, wdata, re, we, instr_retired, tx_ready, rx_data, rx_valid,
        output rdata, tx_data, tx_valid, rx_ready
    );

    modport master (
        output addr, wdata, re, we, instr_retired, tx_ready, rx_data, rx_valid,
        input  rdata, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/mmio_io_responder.sv
// MMIO responder: UART TX holding register, RX buffer, cycle and retired-instruction counters.
// Define MMIO_RX_FIFO_EN for a 4-entry RX FIFO; otherwise RX is a single-byte register.
module mmio_io_responder (
    input logic                clk,
    input logic                reset_n,
    mmio_io_responder_if.slave bus
);
    localparam int          DATA_W      = 32;
    localparam logic [3:0]  REGION      = 4'h8;
    localparam logic [27:0] OFS_TX_STAT = 28'h00;
    localparam logic [27:0] OFS_RX_STAT = 28'h04;
    localparam logic [27:0] OFS_TX_DATA = 28'h08;
    localparam logic [27:0] OFS_RX_DATA = 28'h0C;
    localparam logic [27:0] OFS_CYC     = 28'h10;
    localparam logic [27:0] OFS_INS     = 28'h14;
    localparam logic [27:0] OFS_CLR     = 28'h18;

    logic              in_region;
    logic              tx_full;
    logic [7:0]        tx_data_q;
    logic [DATA_W-1:0] rdata_p0;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] cyc_cnt;
    logic [DATA_W-1:0] ins_cnt;
    logic              rx_full;
    logic              rx_nonempty;
    logic [7:0]        rx_head;
    logic              tx_load;
    logic              tx_hs;
    logic              rx_push;
    logic              rx_pop;
    logic              cnt_clr;
    logic              unused_wdata_hi;

    function automatic logic ofs_hit(input logic region_ok, input logic [27:0] a,
                                     input logic [27:0] ofs);
        return region_ok && (a == ofs);
    endfunction

    assign in_region = (bus.addr[31:28] == REGION);
    assign tx_hs     = tx_full & bus.tx_ready;
    // A handshake only happens while full, so a same-cycle write is rejected by ~tx_full.
    assign tx_load   = bus.we & ofs_hit(in_region, bus.addr[27:0], OFS_TX_DATA) & ~tx_full;
    assign rx_push   = bus.rx_valid & ~rx_full;
    assign rx_pop    = bus.re & ofs_hit(in_region, bus.addr[27:0], OFS_RX_DATA) & rx_nonempty;
    assign cnt_clr   = bus.we & ofs_hit(in_region, bus.addr[27:0], OFS_CLR);
    assign unused_wdata_hi = ^bus.wdata[31:8];

    always_comb begin
        rd_val = '0;
        if (in_region) begin
            case (bus.addr[27:0])
                OFS_TX_STAT: rd_val = {31'b0, ~tx_full};
                OFS_RX_STAT: rd_val = {31'b0, rx_nonempty};
                OFS_RX_DATA: rd_val = rx_nonempty ? {24'b0, rx_head} : '0;
                OFS_CYC:     rd_val = cyc_cnt;
                OFS_INS:     rd_val = ins_cnt;
                default:     rd_val = '0;
            endcase
        end
    end

    // Stage p0: registered load data, held while no load is issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_p0 <= '0;
        end else if (bus.re) begin
            rdata_p0 <= rd_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_full   <= 1'b0;
            tx_data_q <= '0;
        end else if (tx_hs) begin
            tx_full <= 1'b0;
        end else if (tx_load) begin
            tx_full   <= 1'b1;
            tx_data_q <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            ins_cnt <= ins_cnt + {31'b0, bus.instr_retired};
        end
    end

`ifdef MMIO_RX_FIFO_EN
    logic [7:0] rx_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] rx_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) wr_ptr <= wr_ptr + 2'd1;
            if (rx_pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 3'd1;
                2'b01:   rx_cnt <= rx_cnt - 3'd1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[wr_ptr] <= bus.rx_data;
    end

    assign rx_full     = (rx_cnt == 3'd4);
    assign rx_nonempty = (rx_cnt != 3'd0);
    assign rx_head     = rx_mem[rd_ptr];
`else
    logic [7:0] rx_byte;
    logic       rx_occ;

    // Push needs empty and pop needs non-empty, so they never coincide here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_occ <= 1'b0;
        end else if (rx_push) begin
            rx_occ <= 1'b1;
        end else if (rx_pop) begin
            rx_occ <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_byte <= bus.rx_data;
    end

    assign rx_full     = rx_occ;
    assign rx_nonempty = rx_occ;
    assign rx_head     = rx_byte;
`endif

    assign bus.rdata    = rdata_p0;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_full;
    assign bus.rx_ready = ~rx_full;
endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder; expectations follow MMIO_RX_FIFO_EN when defined.
module tb_mmio_io_responder;
    logic clk;
    logic reset_n;
    int   nchk;
    int   nfail;

    mmio_io_responder_if bus ();

    mmio_io_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.re   = 1'b1;
        cyc();
        bus.re   = 1'b0;
        d        = bus.rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        cyc();
        bus.we    = 1'b0;
    endtask

    logic [31:0] d;
    logic [7:0]  exp_rx  [5];
    logic [7:0]  exp_rx2 [3];

    initial begin
        nchk = 0;
        nfail = 0;
        clk = 1'b0;
        reset_n = 1'b1;
        bus.addr = '0;
        bus.wdata = '0;
        bus.re = 1'b0;
        bus.we = 1'b0;
        bus.instr_retired = 1'b0;
        bus.tx_ready = 1'b0;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;
`ifdef MMIO_RX_FIFO_EN
        exp_rx  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00};
        exp_rx2 = '{8'h21, 8'h22, 8'h00};
`else
        exp_rx  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_rx2 = '{8'h00, 8'h00, 8'h00};
`endif
        #1 reset_n = 1'b0;
        #11;
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, bus.tx_data}, 32'h0);
        check("rst_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
        #10 reset_n = 1'b1;

        // First accesses after reset
        rd(32'h8000_0000, d); check("tx_stat_init", d, 32'h1);
        rd(32'h8000_0004, d); check("rx_stat_init", d, 32'h0);
        rd(32'h8000_0010, d); check("cyc_init", d, 32'h2);
        cyc();                check("rdata_hold", bus.rdata, 32'h2);
        rd(32'h8000_0020, d); check("unmapped", d, 32'h0);
        rd(32'h8000_0008, d); check("read_wo_08", d, 32'h0);
        rd(32'h9000_0010, d); check("wrong_region", d, 32'h0);
        rd(32'h8000_0018, d); check("read_wo_18", d, 32'h0);
        check("wo_read_no_tx", {31'b0, bus.tx_valid}, 32'h0);

        // TX stall then handshake
        wr(32'h8000_0008, 32'h41);
        check("tx_valid_load", {31'b0, bus.tx_valid}, 32'h1);
        check("tx_data_load", {24'b0, bus.tx_data}, 32'h41);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("tx_valid_stall", {31'b0, bus.tx_valid}, 32'h1);
            check("tx_data_stall", {24'b0, bus.tx_data}, 32'h41);
        end
        wr(32'h8000_0008, 32'h42);
        check("tx_drop_full", {24'b0, bus.tx_data}, 32'h41);
        rd(32'h8000_0000, d); check("tx_stat_full", d, 32'h0);
        bus.tx_ready = 1'b1;
        cyc();
        bus.tx_ready = 1'b0;
        check("tx_hs_clear", {31'b0, bus.tx_valid}, 32'h1 ^ 32'h1);
        rd(32'h8000_0000, d); check("tx_stat_after", d, 32'h1);

        // Write racing a handshake is dropped
        wr(32'h8000_0008, 32'h55);
        bus.tx_ready = 1'b1;
        wr(32'h8000_0008, 32'h66);
        bus.tx_ready = 1'b0;
        check("tx_race_drop", {31'b0, bus.tx_valid}, 32'h0);
        rd(32'h8000_0000, d); check("tx_stat_race", d, 32'h1);

        // Simultaneous load and store at 0x08
        bus.addr = 32'h8000_0008;
        bus.wdata = 32'h77;
        bus.re = 1'b1;
        bus.we = 1'b1;
        cyc();
        bus.re = 1'b0;
        bus.we = 1'b0;
        check("rw_rdata", bus.rdata, 32'h0);
        check("rw_tx_data", {24'b0, bus.tx_data}, 32'h77);
        bus.tx_ready = 1'b1;
        cyc();
        bus.tx_ready = 1'b0;
        check("rw_tx_drain", {31'b0, bus.tx_valid}, 32'h0);

        // RX fill beyond capacity
        for (int i = 0; i < 5; i++) begin
            bus.rx_data = 8'h10 + 8'(i);
            bus.rx_valid = 1'b1;
            cyc();
`ifdef MMIO_RX_FIFO_EN
            if (i == 2) check("rx_ready_3", {31'b0, bus.rx_ready}, 32'h1);
`endif
        end
        bus.rx_valid = 1'b0;
        check("rx_ready_full", {31'b0, bus.rx_ready}, 32'h0);
        rd(32'h8000_0004, d); check("rx_stat_ne", d, 32'h1);
        for (int i = 0; i < 5; i++) begin
            rd(32'h8000_000C, d);
            check("rx_pop", d, {24'b0, exp_rx[i]});
        end
        check("rx_ready_empty", {31'b0, bus.rx_ready}, 32'h1);

        // Push and pop on the same edge
        for (int i = 0; i < 2; i++) begin
            bus.rx_data = 8'h20 + 8'(i);
            bus.rx_valid = 1'b1;
            cyc();
        end
        bus.rx_data = 8'h22;
        bus.addr = 32'h8000_000C;
        bus.re = 1'b1;
        cyc();
        bus.re = 1'b0;
        bus.rx_valid = 1'b0;
        check("rx_pp_head", bus.rdata, 32'h20);
        check("rx_pp_ready", {31'b0, bus.rx_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            rd(32'h8000_000C, d);
            check("rx_pp_order", d, {24'b0, exp_rx2[i]});
        end

        // Instruction counter and clear priority
        wr(32'h8000_0018, 32'h0);
        for (int i = 0; i < 5; i++) begin
            bus.instr_retired = 1'b1;
            cyc();
            bus.instr_retired = 1'b0;
            cyc();
        end
        rd(32'h8000_0014, d); check("ins_cnt5", d, 32'h5);
        bus.instr_retired = 1'b1;
        wr(32'h8000_0018, 32'h0);
        bus.instr_retired = 1'b0;
        rd(32'h8000_0014, d); check("ins_clr", d, 32'h0);
        rd(32'h8000_0010, d); check("cyc_after_clr", d, 32'h1);

        // Cycle counter wrap
        force dut.cyc_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_cnt;
        bus.addr = 32'h8000_0010;
        bus.re = 1'b1;
        cyc();
        check("cyc_max", bus.rdata, 32'hFFFF_FFFF);
        cyc();
        bus.re = 1'b0;
        check("cyc_wrap", bus.rdata, 32'h0);

        // Asynchronous reset with TX and RX bytes pending
        wr(32'h8000_0008, 32'h5A);
        bus.rx_data = 8'h33;
        bus.rx_valid = 1'b1;
        cyc();
        bus.rx_valid = 1'b0;
        rd(32'h8000_0004, d); check("pre_rst_rx", d, 32'h1);
        check("pre_rst_tx", {31'b0, bus.tx_valid}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
        check("arst_tx_data", {24'b0, bus.tx_data}, 32'h0);
        check("arst_rdata", bus.rdata, 32'h0);
        check("arst_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
        #3 reset_n = 1'b1;
        rd(32'h8000_0004, d); check("post_rst_rx", d, 32'h0);
        rd(32'h8000_0000, d); check("post_rst_tx", d, 32'h1);
        rd(32'h8000_0014, d); check("post_rst_ins", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
